serial_sram_loader: RTL

- Receive-side deserializer for the chip's serial load interface; counterpart of the output serializer.
- Shifts 16-bit words in LSB-first from serial_in while load_en is high.
- Routes each completed word to a write port on one of four SRAMs (phase vector, TF coefficients, magnitude, phase out), selected by sram_select, with an auto-incrementing address.
- When adc_bypass_en is high, a completed word goes to the ADC bypass register instead of an SRAM.

---
 rtl/serial_sram_loader_pkg.sv | 19 +
 rtl/serial_shift_in.sv | 37 +++
 rtl/serial_sram_loader.sv | 86 ++++++++
 3 files changed

// File: rtl/serial_sram_loader_pkg.sv
// rtl/serial_sram_loader_pkg.sv - shared widths, SRAM select codes and load FSM states
package serial_sram_loader_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 12;
  localparam int SEL_WIDTH_DEF  = 2;

  localparam logic [1:0] SEL_PHASE_VEC = 2'd0;
  localparam logic [1:0] SEL_TF_COEFF  = 2'd1;
  localparam logic [1:0] SEL_MAG_OUT   = 2'd2;
  localparam logic [1:0] SEL_PHASE_OUT = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } load_state_e;

endpackage

// File: rtl/serial_shift_in.sv
// rtl/serial_shift_in.sv - LSB-first serial-to-parallel shifter with bit counter and word_done strobe
module serial_shift_in
  import serial_sram_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_done
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;

  // The word includes the bit being sampled now, so a consumer can commit on the last-bit edge.
  assign word      = {serial_in, shreg[DATA_WIDTH-1:1]};
  assign word_done = shift_en && (bit_cnt == LAST_BIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (!shift_en) begin
      bit_cnt <= '0;
    end else begin
      shreg   <= word;
      bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_sram_loader.sv
// rtl/serial_sram_loader.sv - serial load deserializer routing words to SRAM write ports or the ADC bypass register
module serial_sram_loader
  import serial_sram_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int SEL_WIDTH  = SEL_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_en,
  input  logic                     serial_in,
  input  logic [SEL_WIDTH-1:0]     sram_select,
  input  logic                     adc_bypass_en,
  output logic                     wr_en,
  output logic [(1<<SEL_WIDTH)-1:0] wr_sel,
  output logic [ADDR_WIDTH-1:0]    wr_addr,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic [DATA_WIDTH-1:0]    bypass_data,
  output logic                     bypass_valid,
  output logic [ADDR_WIDTH:0]      word_count,
  output logic                     overflow
);

  localparam int NSRAM = 1 << SEL_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
  localparam logic [NSRAM-1:0] SEL_ONE = {{(NSRAM-1){1'b0}}, 1'b1};

  load_state_e           state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] word;
  logic                  word_done;

  serial_shift_in #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .shift_en (load_en),
    .serial_in(serial_in),
    .word     (word),
    .word_done(word_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      addr         <= '0;
      wr_en        <= 1'b0;
      wr_sel       <= '0;
      wr_addr      <= '0;
      wr_data      <= '0;
      bypass_data  <= '0;
      bypass_valid <= 1'b0;
      word_count   <= '0;
      overflow     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (!load_en) begin
        // Closing the window rewinds the address so the next load starts at 0.
        state      <= IDLE;
        addr       <= '0;
        word_count <= '0;
      end else begin
        if (state == IDLE) state <= SHIFT;
        if (word_done) begin
          if (adc_bypass_en) begin
            bypass_data  <= word;
            bypass_valid <= 1'b1;
          end else if (state == FULL) begin
            overflow <= 1'b1;
          end else begin
            wr_en      <= 1'b1;
            wr_data    <= word;
            wr_addr    <= addr;
            wr_sel     <= SEL_ONE << sram_select;
            addr       <= addr + 1'b1;
            word_count <= word_count + 1'b1;
            if (addr == ADDR_LAST) state <= FULL;
          end
        end
      end
    end
  end

endmodule
